// File: rtl/rf_pkg.sv
// Shared register-file write types and constants for the multi-cycle RISC-V core.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Writeback request bundle: per-requester valid/ready plus flattened addr/data.
interface rf_wr_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/rr_arb.sv
// Round-robin priority picker: first set request at or after ptr (mod N) wins.
module rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found_s;
  logic hit_s;
  int   j_s;

  // Rotating scan starting at the pointer; at most one hit.
  always_comb begin
    gnt_o   = {N{1'b0}};
    idx_o   = {IW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    j_s     = 0;
    for (int k = 0; k < N; k++) begin
      j_s        = (int'(ptr_i) + k >= N) ? int'(ptr_i) + k - N : int'(ptr_i) + k;
      hit_s      = en_i && !found_s && req_i[j_s];
      gnt_o[j_s] = hit_s;
      idx_o      = hit_s ? IW'(j_s) : idx_o;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with x0
// suppression, one registered output stage and read-side bypass.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  rf_wr_arbiter_if.slave      req,
  output logic                web,
  output logic [AW-1:0]       da,
  output logic [DW-1:0]       din,
  input  logic [AW-1:0]       a1,
  input  logic [AW-1:0]       a2,
  input  logic [DW-1:0]       d1,
  input  logic [DW-1:0]       d2,
  output logic [DW-1:0]       fd1,
  output logic [DW-1:0]       fd2,
  output logic [(2**AW)-1:0]  busy,
  output logic [15:0]         wr_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 2 ** AW;

  logic [PW-1:0]   ptr_q, ptr_d, gnt_idx_s;
  logic [NREQ-1:0] gnt_s;
  logic            accept_s, commit_s;
  wr_req_t         sel_s;
  logic            web_q, web_d;
  logic [AW-1:0]   da_q, da_d;
  logic [DW-1:0]   din_q, din_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [NR-1:0]   busy_s;

  // Grants are suppressed during reset so nothing is released into a dead stage.
  rr_arb #(.N(NREQ), .IW(PW)) u_rr_arb (
    .req_i (req.req_valid),
    .ptr_i (ptr_q),
    .en_i  (!hold && rst_n),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s)
  );

  assign req.req_ready = gnt_s;
  assign accept_s      = |(gnt_s & req.req_valid);
  assign commit_s      = accept_s && (sel_s.addr != REG_X0);

  // One-hot AND-OR mux of the granted request.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_s.addr = sel_s.addr | (req.req_addr[i*AW +: AW] & {AW{gnt_s[i]}});
      sel_s.data = sel_s.data | (req.req_data[i*DW +: DW] & {DW{gnt_s[i]}});
    end
  end

  // Next-state for pointer, output stage and commit counter.
  always_comb begin
    ptr_d    = ptr_q;
    da_d     = da_q;
    din_d    = din_q;
    web_d    = commit_s;
    wr_cnt_d = wr_cnt_q;
    if (accept_s) begin
      ptr_d = (gnt_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
      da_d  = sel_s.addr;
      din_d = sel_s.data;
    end else begin
      ptr_d = ptr_q;
    end
    if (commit_s) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // State registers; reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= {PW{1'b0}};
      web_q    <= 1'b0;
      da_q     <= {AW{1'b0}};
      din_q    <= {DW{1'b0}};
      wr_cnt_q <= 16'd0;
    end else begin
      ptr_q    <= ptr_d;
      web_q    <= web_d;
      da_q     <= da_d;
      din_q    <= din_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Pending-write bitmap: output stage plus every outstanding request.
  always_comb begin
    busy_s = {NR{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      busy_s[req.req_addr[i*AW +: AW]] = busy_s[req.req_addr[i*AW +: AW]] | req.req_valid[i];
    end
    busy_s[da_q] = busy_s[da_q] | web_q;
    busy_s[0]    = 1'b0;
  end

  assign fd1    = (a1 == REG_X0) ? {DW{1'b0}} : ((web_q && da_q == a1) ? din_q : d1);
  assign fd2    = (a2 == REG_X0) ? {DW{1'b0}} : ((web_q && da_q == a2) ? din_q : d2);
  assign busy   = busy_s;
  assign web    = web_q;
  assign da     = da_q;
  assign din    = din_q;
  assign wr_cnt = wr_cnt_q;

endmodule
